// File: rtl/uart_pkg.sv
// Shared types and constants for the cipher-block UART transmitter.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 5000;
  localparam int BLOCK_W = 128;
  localparam int CNT_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } uart_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SEND,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// Serialises one byte: start, 8 data bits LSB first, optional parity, stop.
// Parity stage exists only when UART_TX_PARITY_EN is defined.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       res,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       last
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      st;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       sr;
  logic             tick;
`ifdef UART_TX_PARITY_EN
  logic             par;
`endif

  assign tick = (cnt == CNT_MAX);
  // high in the final cycle of the stop bit so the next byte can follow gaplessly
  assign last = (st == STOP) && tick;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      st      <= IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (load) begin
      st      <= START;
      tx      <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= data;
`ifdef UART_TX_PARITY_EN
      par     <= ^data;
`endif
    end else begin
      if (st == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end
      unique case (st)
        IDLE: begin
          tx <= 1'b1;
        end
        START: begin
          if (tick) begin
            st <= DATA;
            tx <= sr[0];
            sr <= sr >> 1;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              st <= PARITY;
              tx <= par;
`else
              st <= STOP;
              tx <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= sr[0];
              sr      <= sr >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            st <= STOP;
            tx <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            st <= IDLE;
            tx <= 1'b1;
          end
        end
        default: begin
          st <= IDLE;
          tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_cipher_tx.sv
// Sends 128-bit cipher blocks byte by byte over a UART line and counts blocks.
// Define UART_TX_PARITY_EN to add an even-parity bit to every byte.
module uart_cipher_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int NUM_BYTES    = 16
) (
  input  logic               clk,
  input  logic               res,
  input  logic [BLOCK_W-1:0] block_in,
  input  logic               block_valid,
  output logic               block_ready,
  input  logic [31:0]        total_blocks,
  output logic               TX,
  output logic               busy,
  output logic               out_ok,
  output logic               all_done,
  output logic [31:0]        blocks_sent
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_BYTES - 1);

  seq_state_t         st;
  logic [BLOCK_W-1:0] blk_sr;
  logic [4:0]         byte_idx;
  logic               accept;
  logic               byte_last;
  logic               final_byte;
  logic               next_load;
  logic [7:0]         load_data;
  logic [31:0]        sent_nx;

  assign accept     = (st == SEQ_IDLE) && block_valid && block_ready;
  assign final_byte = (byte_idx == LAST_IDX);
  assign next_load  = (st == SEQ_SEND) && byte_last && !final_byte;
  assign load_data  = accept ? block_in[7:0] : blk_sr[15:8];

  // a new message starts from zero once the previous one is complete
  always_comb begin
    sent_nx = blocks_sent;
    if (accept && all_done) begin
      sent_nx = '0;
    end else if ((st == SEQ_SEND) && byte_last && final_byte) begin
      sent_nx = blocks_sent + 32'd1;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk (clk),
    .res (res),
    .load(accept || next_load),
    .data(load_data),
    .tx  (TX),
    .last(byte_last)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      st          <= SEQ_IDLE;
      block_ready <= 1'b0;
      busy        <= 1'b0;
      out_ok      <= 1'b0;
      all_done    <= 1'b0;
      blocks_sent <= '0;
      blk_sr      <= '0;
      byte_idx    <= '0;
    end else begin
      out_ok      <= 1'b0;
      blocks_sent <= sent_nx;
      all_done    <= (sent_nx == total_blocks) &&
                     (total_blocks != 32'd0);
      unique case (st)
        SEQ_IDLE: begin
          if (accept) begin
            st          <= SEQ_SEND;
            busy        <= 1'b1;
            block_ready <= 1'b0;
            blk_sr      <= block_in;
            byte_idx    <= '0;
          end else begin
            block_ready <= 1'b1;
          end
        end
        SEQ_SEND: begin
          if (byte_last) begin
            if (final_byte) begin
              st     <= SEQ_DONE;
              busy   <= 1'b0;
              out_ok <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 5'd1;
              blk_sr   <= blk_sr >> 8;
            end
          end
        end
        SEQ_DONE: begin
          st          <= SEQ_IDLE;
          block_ready <= 1'b1;
        end
        default: begin
          st <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule
